cam_capture_rgb332: RTL and testbench

Camera capture stage upstream of the dual-port frame buffer. Samples an OV7670-style parallel stream (VSYNC/HREF/8-bit data, two bytes per RGB565 pixel), packs each pixel to RGB332 and drives the buffer's write port (address, data, write strobe) for one frame per `init` request from the LM32. Reports `busy`/`done` to the SoC register wrapper.

---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_pixel_counter.sv | 78 +++++++
 rtl/cam_capture_rgb332.sv | 148 ++++++++++++++
 tb/tb_cam_capture_rgb332.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: default image geometry,
// capture state encoding and the RGB565 -> RGB332 packing function.
`timescale 1ns/1ps

package cam_pkg;

   localparam int IMG_W_DEF = 160;
   localparam int IMG_H_DEF = 120;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_BYTE1      = 2'd2,
      ST_BYTE2      = 2'd3
   } cam_state_e;

   // Keep the top bits of each colour field: R5->R3, G6->G3, B5->B2.
   function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi,
                                                input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

endpackage

// File: rtl/cam_pixel_counter.sv
// Column/row counters with incremental frame buffer addressing.
// Ports: clear (frame start), pixel_tick (one packed pixel), line_end
// (href falling edge) -> addr (row*IMG_W+col), in_win (pixel is stored).
`timescale 1ns/1ps

module cam_pixel_counter
   import cam_pkg::*;
#(
   parameter int AW    = 15,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int CW    = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          pixel_tick,
   input  logic          line_end,
   output logic [AW-1:0] addr,
   output logic          in_win
);

   localparam logic [CW-1:0] W_C = CW'(IMG_W);
   localparam logic [CW-1:0] H_C = CW'(IMG_H);
   localparam logic [AW-1:0] W_A = AW'(IMG_W);

   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] addr_q, addr_d;

   assign in_win = (col_q < W_C) && (row_q < H_C);
   assign addr   = addr_q;

   // base_q tracks row*IMG_W so a new line starts without a multiply.
   // Rows saturate at IMG_H so the base never runs past the window.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      base_d = base_q;
      addr_d = addr_q;
      if (clear) begin
         col_d  = '0;
         row_d  = '0;
         base_d = '0;
         addr_d = '0;
      end else if (line_end) begin
         col_d = '0;
         if (row_q < H_C) begin
            row_d  = row_q + 1'b1;
            base_d = base_q + W_A;
            addr_d = base_q + W_A;
         end
      end else if (pixel_tick) begin
         if (col_q != '1) begin
            col_d = col_q + 1'b1;
         end
         if (in_win) begin
            addr_d = addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q  <= '0;
         row_q  <= '0;
         base_q <= '0;
         addr_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         base_q <= base_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/cam_capture_rgb332.sv
// OV7670-style capture: two RGB565 bytes per pixel packed to RGB332 and
// written to the frame buffer (addr/data/regwrite), one frame per init.
// Status: busy while capturing, done sticky until the next accepted init.
`timescale 1ns/1ps

module cam_capture_rgb332
   import cam_pkg::*;
#(
   parameter int AW    = 15,
   parameter int DW    = 8,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          regwrite,
   output logic          busy,
   output logic          done
);

   cam_state_e    state_q, state_d;
   logic          vsync_q;
   logic          href_q;
   logic [7:0]    hi_q, hi_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          regwrite_q, regwrite_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          cnt_clear;
   logic          cnt_tick;
   logic          cnt_line_end;
   logic [AW-1:0] cnt_addr;
   logic          cnt_in_win;

   logic          vs_fall;
   logic          vs_rise;
   logic          hr_fall;

   assign vs_fall = vsync_q & ~vsync;
   assign vs_rise = ~vsync_q & vsync;
   assign hr_fall = href_q & ~href;

   cam_pixel_counter #(
      .AW    (AW),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .pixel_tick (cnt_tick),
      .line_end   (cnt_line_end),
      .addr       (cnt_addr),
      .in_win     (cnt_in_win)
   );

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      addr_d       = addr_q;
      data_d       = data_q;
      regwrite_d   = 1'b0;
      done_d       = done_q;
      cnt_clear    = 1'b0;
      cnt_tick     = 1'b0;
      cnt_line_end = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (init) begin
               state_d = ST_WAIT_FRAME;
               done_d  = 1'b0;
            end
         end
         ST_WAIT_FRAME: begin
            if (vs_fall) begin
               state_d   = ST_BYTE1;
               cnt_clear = 1'b1;
               addr_d    = '0;
            end
         end
         ST_BYTE1, ST_BYTE2: begin
            // Frame end wins over line end and any pending hi byte.
            if (vs_rise) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_line_end = hr_fall;
               if (state_q == ST_BYTE1) begin
                  if (href) begin
                     hi_d    = px_data;
                     state_d = ST_BYTE2;
                  end
               end else begin
                  state_d = ST_BYTE1;
                  if (href) begin
                     cnt_tick   = 1'b1;
                     regwrite_d = cnt_in_win;
                     if (cnt_in_win) begin
                        addr_d = cnt_addr;
                        data_d = DW'(rgb565_to_332(hi_q, px_data));
                     end
                  end
               end
            end
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         hi_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         regwrite_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vsync_q    <= vsync;
         href_q     <= href;
         hi_q       <= hi_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         regwrite_q <= regwrite_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign addr     = addr_q;
   assign data     = data_q;
   assign regwrite = regwrite_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Testbench for cam_capture_rgb332: directed camera streams, a frame-level
// reference model compared every cycle, plus literal spot checks.
`timescale 1ns/1ps

module tb_cam_capture_rgb332;

   localparam int W = 160;
   localparam int H = 120;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init = 1'b0;
   logic        vsync = 1'b1;
   logic        href = 1'b0;
   logic [7:0]  px = 8'd0;
   logic [14:0] addr;
   logic [7:0]  data;
   logic        regwrite;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   cam_capture_rgb332 dut (
      .clk      (clk),
      .rst      (rst),
      .init     (init),
      .vsync    (vsync),
      .href     (href),
      .px_data  (px),
      .addr     (addr),
      .data     (data),
      .regwrite (regwrite),
      .busy     (busy),
      .done     (done)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int a;
      int d;
   } wr_t;
   wr_t log_q[$];

   // Reference model: frame phase, pixel position and pending hi byte.
   int         m_phase = 0;
   int         m_col = 0;
   int         m_row = 0;
   bit         m_hv = 1'b0;
   bit         m_pv = 1'b0;
   bit         m_ph = 1'b0;
   logic [7:0] m_hi = 8'd0;
   bit         e_wr = 1'b0;
   bit         e_busy = 1'b0;
   bit         e_done = 1'b0;
   int         e_addr = 0;
   int         e_data = 0;

   function automatic int pack(input logic [7:0] hi, input logic [7:0] lo);
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
      r = hi[7:3];
      g = {hi[2:0], lo[7:5]};
      b = lo[4:0];
      return int'({r[4:2], g[5:3], b[4:3]});
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_col = 0;
         m_row = 0;
         m_hv = 1'b0;
         m_pv = 1'b0;
         m_ph = 1'b0;
         e_wr = 1'b0;
         e_busy = 1'b0;
         e_done = 1'b0;
      end else begin
         e_wr = 1'b0;
         if (m_phase == 0) begin
            if (init) begin
               m_phase = 1;
               e_done = 1'b0;
            end
         end else if (m_phase == 1) begin
            if (m_pv && !vsync) begin
               m_phase = 2;
               m_col = 0;
               m_row = 0;
               m_hv = 1'b0;
            end
         end else begin
            if (!m_pv && vsync) begin
               m_phase = 0;
               e_done = 1'b1;
               m_hv = 1'b0;
            end else begin
               if (m_ph && !href) begin
                  m_col = 0;
                  m_row = m_row + 1;
               end
               if (!href) begin
                  m_hv = 1'b0;
               end else if (!m_hv) begin
                  m_hi = px;
                  m_hv = 1'b1;
               end else begin
                  if (m_col < W && m_row < H) begin
                     e_wr = 1'b1;
                     e_addr = m_row * W + m_col;
                     e_data = pack(m_hi, px);
                  end
                  m_col = m_col + 1;
                  m_hv = 1'b0;
               end
            end
         end
         e_busy = (m_phase != 0);
         m_pv = vsync;
         m_ph = href;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (regwrite !== e_wr) begin
         errors++;
         $display("FAIL regwrite t=%0t got=%b want=%b", $time, regwrite, e_wr);
      end
      if (regwrite === 1'b1) begin
         log_q.push_back('{int'(addr), int'(data)});
         if (e_wr) begin
            checks++;
            if (int'(addr) != e_addr || int'(data) != e_data) begin
               errors++;
               $display("FAIL write t=%0t got=%0d/%02h want=%0d/%02h",
                        $time, addr, data, e_addr, e_data);
            end
         end
      end
      checks++;
      if (busy !== e_busy || done !== e_done) begin
         errors++;
         $display("FAIL status t=%0t got busy=%b done=%b want busy=%b done=%b",
                  $time, busy, done, e_busy, e_done);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input logic [7:0] hi, input logic [7:0] lo);
      href = 1'b1;
      px = hi;
      step();
      px = lo;
      step();
   endtask

   task automatic gap();
      href = 1'b0;
      px = 8'd0;
      repeat (4) step();
   endtask

   task automatic pulse_init();
      init = 1'b1;
      step();
      init = 1'b0;
   endtask

   task automatic vs_fall();
      vsync = 1'b1;
      repeat (3) step();
      vsync = 1'b0;
      repeat (2) step();
   endtask

   task automatic vs_rise();
      href = 1'b0;
      vsync = 1'b1;
      repeat (3) step();
   endtask

   task automatic pat_line(input int n, input int row);
      for (int i = 0; i < n; i++) begin
         pixel(8'(i * 3 + row), 8'(i * 5 + row * 11));
      end
      gap();
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk("rst_done", int'(done), 0);
      rst = 1'b0;
      step();

      // Reset while a pixel is half received
      pulse_init();
      vs_fall();
      href = 1'b1;
      px = 8'hAB;
      step();
      px = 8'hCD;
      rst = 1'b1;
      #1;
      chk("t1_addr", int'(addr), 0);
      chk("t1_data", int'(data), 0);
      chk("t1_regwrite", int'(regwrite), 0);
      chk("t1_busy", int'(busy), 0);
      chk("t1_done", int'(done), 0);
      step();
      rst = 1'b0;
      href = 1'b0;
      repeat (4) step();
      chk("t1_nowrite", log_q.size(), 0);

      // Four-pixel line with hand-packed colours
      log_q.delete();
      pulse_init();
      vs_fall();
      pixel(8'hF8, 8'h00);
      pixel(8'h07, 8'hE0);
      pixel(8'h00, 8'h1F);
      pixel(8'hFF, 8'hFF);
      gap();
      chk("t2_count", log_q.size(), 4);
      if (log_q.size() == 4) begin
         chk("t2_d0", log_q[0].d, 'hE0);
         chk("t2_d1", log_q[1].d, 'h1C);
         chk("t2_d2", log_q[2].d, 'h03);
         chk("t2_d3", log_q[3].d, 'hFF);
         chk("t2_a3", log_q[3].a, 3);
      end
      chk("t2_busy", int'(busy), 1);
      vs_rise();
      chk("t2_done", int'(done), 1);
      chk("t2_idle", int'(busy), 0);

      // Overlong line is cropped, next line starts at 160
      log_q.delete();
      pulse_init();
      chk("t3_done_clr", int'(done), 0);
      chk("t3_busy", int'(busy), 1);
      vs_fall();
      pat_line(170, 0);
      pat_line(3, 1);
      chk("t3_count", log_q.size(), 163);
      if (log_q.size() == 163) begin
         chk("t3_a0", log_q[0].a, 0);
         chk("t3_a159", log_q[159].a, 159);
         chk("t3_a160", log_q[160].a, 160);
      end
      vs_rise();

      // Odd byte count before href drop, init ignored while busy
      log_q.delete();
      pulse_init();
      vs_fall();
      pixel(8'h12, 8'h34);
      pixel(8'h56, 8'h78);
      px = 8'hF0;
      step();
      href = 1'b0;
      init = 1'b1;
      step();
      init = 1'b0;
      repeat (3) step();
      chk("t4_busy", int'(busy), 1);
      pixel(8'hF8, 8'h00);
      gap();
      chk("t4_count", log_q.size(), 3);
      if (log_q.size() == 3) begin
         chk("t4_d0", log_q[0].d, 'h0A);
         chk("t4_d1", log_q[1].d, 'h5B);
         chk("t4_a2", log_q[2].a, 160);
         chk("t4_d2", log_q[2].d, 'hE0);
      end
      vs_rise();
      chk("t4_done", int'(done), 1);

      // Frame without init
      log_q.delete();
      vs_fall();
      pat_line(4, 0);
      vs_rise();
      chk("t5_nowrite", log_q.size(), 0);
      chk("t5_done", int'(done), 1);
      chk("t5_busy", int'(busy), 0);

      // Full frame plus extra lines
      log_q.delete();
      pulse_init();
      chk("t6_done_clr", int'(done), 0);
      vs_fall();
      for (int r = 0; r < H + 5; r++) begin
         pat_line(W, r);
      end
      chk("t6_count", log_q.size(), W * H);
      if (log_q.size() == W * H) begin
         chk("t6_last", log_q[W * H - 1].a, 19199);
         chk("t6_a800", log_q[800].a, 800);
      end
      vs_rise();
      chk("t6_done", int'(done), 1);
      chk("t6_busy", int'(busy), 0);

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
